// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int XLEN_DEF = 32;
    // Wide enough for a full 2*XLEN product at the largest supported XLEN (64).
    localparam int ABS_W    = 128;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    // Magnitude of a zero-extended value whose original sign is given by negative;
    // the same conditional negate re-applies a sign to a magnitude.
    function automatic logic [ABS_W-1:0] abs_val(input logic [ABS_W-1:0] value,
                                                 input logic negative);
        logic [ABS_W-1:0] res;
        if (negative) begin
            res = ~value + ABS_W'(1'b1);
        end else begin
            res = value;
        end
        return res;
    endfunction

endpackage

// File: rtl/muldiv_iterative_unit_if.sv
// Start/busy/done handshake between the hazard unit (master) and the muldiv unit (slave).
interface muldiv_iterative_unit_if
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
);
    logic            start;
    logic            flush;
    logic [2:0]      op;
    logic [XLEN-1:0] operand1;
    logic [XLEN-1:0] operand2;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, flush, op, operand1, operand2,
        input  busy, done, result
    );

    modport slave (
        input  start, flush, op, operand1, operand2,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_sign_fixup.sv
// Re-applies operand signs to the unsigned iteration result and selects the output field.
module muldiv_sign_fixup
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  op_e               op_i,
    input  logic [2*XLEN-1:0] raw_i,      // product, or {remainder, quotient}
    input  logic              res_neg_i,
    input  logic              rem_neg_i,
    output logic [XLEN-1:0]   result_o
);
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quot_s;
    logic [XLEN-1:0]   rem_s;

    assign prod_s = (2*XLEN)'(abs_val(ABS_W'(raw_i), res_neg_i));
    assign quot_s = XLEN'(abs_val(ABS_W'(raw_i[XLEN-1:0]), res_neg_i));
    assign rem_s  = XLEN'(abs_val(ABS_W'(raw_i[2*XLEN-1:XLEN]), rem_neg_i));

    // Field select by operation.
    always_comb begin
        result_o = {XLEN{1'b0}};
        case (op_i)
            OP_MUL:                       result_o = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result_o = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              result_o = quot_s;
            OP_REM, OP_REMU:              result_o = rem_s;
            default:                      result_o = {XLEN{1'b0}};
        endcase
    end
endmodule

// File: rtl/muldiv_iterative_unit.sv
// Shared iterative multiply/divide datapath for all eight RV32M operations,
// with radix-configurable shift-add multiply and restoring divide.
module muldiv_iterative_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int MUL_BITS  = 1,
    parameter int EARLY_OUT = 1
) (
    input  logic clk,
    input  logic rst,
    muldiv_iterative_unit_if.slave bus
);
    localparam int              CW       = $clog2(XLEN) + 1;
    localparam int              PW       = XLEN + MUL_BITS;
    localparam logic [CW-1:0]   MUL_LAST = CW'(XLEN / MUL_BITS - 1);
    localparam logic [CW-1:0]   DIV_LAST = CW'(XLEN - 1);
    localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q, state_d;
    op_e               op_q, op_d, op_in_s;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              res_neg_q, res_neg_d;
    logic              rem_neg_q, rem_neg_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [XLEN-1:0]   fixed_s;

    logic              a_signed_s, b_signed_s, a_neg_s, b_neg_s;
    logic              div_zero_s, ovf_s, early_s, accept_s;
    logic [XLEN-1:0]   a_abs_s, b_abs_s;
    logic [PW-1:0]     mul_sum_s;
    logic [XLEN:0]     rem_top_s, rem_diff_s;

    assign op_in_s    = op_e'(bus.op);
    assign a_signed_s = op_in_s inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    assign b_signed_s = op_in_s inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    assign a_neg_s    = a_signed_s & bus.operand1[XLEN-1];
    assign b_neg_s    = b_signed_s & bus.operand2[XLEN-1];
    assign a_abs_s    = XLEN'(abs_val(ABS_W'(bus.operand1), a_neg_s));
    assign b_abs_s    = XLEN'(abs_val(ABS_W'(bus.operand2), b_neg_s));
    assign div_zero_s = (bus.operand2 == ZERO);
    assign ovf_s      = (op_in_s == OP_DIV || op_in_s == OP_REM) &&
                        (bus.operand1 == MIN_INT) && (bus.operand2 == ALL_ONES);
    assign early_s    = (EARLY_OUT != 0) && op_in_s[2] && (div_zero_s || ovf_s);
    assign accept_s   = (state_q == ST_IDLE) && bus.start && !bus.flush;

    // One multiply step adds multiplicand*digit into the high half, then shifts right.
    assign mul_sum_s  = PW'(acc_q[2*XLEN-1:XLEN]) + PW'(opnd_q) * PW'(acc_q[MUL_BITS-1:0]);
    assign rem_top_s  = acc_q[2*XLEN-1:XLEN-1];
    assign rem_diff_s = rem_top_s - {1'b0, opnd_q};

    muldiv_sign_fixup #(.XLEN(XLEN)) u_fixup (
        .op_i      (op_q),
        .raw_i     (acc_q),
        .res_neg_i (res_neg_q),
        .rem_neg_i (rem_neg_q),
        .result_o  (fixed_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!accept_s)        state_d = ST_IDLE;
                else if (early_s)     state_d = ST_FIN;
                else if (op_in_s[2])  state_d = ST_DIV;
                else                  state_d = ST_MUL;
            end
            ST_MUL, ST_DIV: begin
                if (bus.flush)              state_d = ST_IDLE;
                else if (cnt_q == CNT_ZERO) state_d = ST_FIN;
                else                        state_d = state_q;
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        op_d      = op_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        cnt_d     = cnt_q;
        res_neg_d = res_neg_q;
        rem_neg_d = rem_neg_q;
        result_d  = result_q;
        done_d    = (state_q == ST_FIN);
        busy_d    = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    op_d      = op_in_s;
                    rem_neg_d = a_neg_s;
                    // A zero divisor must yield all-ones regardless of dividend sign.
                    res_neg_d = (a_neg_s ^ b_neg_s) & ~(op_in_s[2] & div_zero_s);
                    if (early_s) begin
                        opnd_d = b_abs_s;
                        cnt_d  = CNT_ZERO;
                        acc_d  = div_zero_s ? {a_abs_s, ALL_ONES} : {ZERO, MIN_INT};
                    end else if (op_in_s[2]) begin
                        opnd_d = b_abs_s;
                        cnt_d  = DIV_LAST;
                        acc_d  = {ZERO, a_abs_s};
                    end else begin
                        opnd_d = a_abs_s;
                        cnt_d  = MUL_LAST;
                        acc_d  = {ZERO, b_abs_s};
                    end
                end else begin
                    acc_d = acc_q;
                end
            end
            ST_MUL: begin
                if (!bus.flush) begin
                    acc_d = {mul_sum_s, acc_q[XLEN-1:MUL_BITS]};
                    cnt_d = cnt_q - CW'(1'b1);
                end else begin
                    acc_d = acc_q;
                end
            end
            ST_DIV: begin
                if (bus.flush) begin
                    acc_d = acc_q;
                end else if (rem_diff_s[XLEN]) begin
                    acc_d = {rem_top_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                    cnt_d = cnt_q - CW'(1'b1);
                end else begin
                    acc_d = {rem_diff_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                    cnt_d = cnt_q - CW'(1'b1);
                end
            end
            ST_FIN:  result_d = fixed_s;
            default: result_d = result_q;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q      <= OP_MUL;
            acc_q     <= {(2*XLEN){1'b0}};
            opnd_q    <= ZERO;
            cnt_q     <= CNT_ZERO;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= ZERO;
        end else begin
            op_q      <= op_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            cnt_q     <= cnt_d;
            res_neg_q <= res_neg_d;
            rem_neg_q <= rem_neg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_iterative_unit.sv
// Directed bench for muldiv_iterative_unit: default, radix-16 multiply and no-early-out builds.
module tb_muldiv_iterative_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  start_s = 3'b000;
    logic        flush_s = 1'b0;
    logic [2:0]  op_s = 3'd0;
    logic [31:0] a_s = 32'd0;
    logic [31:0] b_s = 32'd0;
    logic [2:0]  busy_w, done_w;
    logic [31:0] res_w [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    muldiv_iterative_unit_if #(.XLEN(32)) bus0 ();
    muldiv_iterative_unit_if #(.XLEN(32)) bus1 ();
    muldiv_iterative_unit_if #(.XLEN(32)) bus2 ();

    assign bus0.start = start_s[0];
    assign bus1.start = start_s[1];
    assign bus2.start = start_s[2];
    assign bus0.flush = flush_s;
    assign bus1.flush = flush_s;
    assign bus2.flush = flush_s;
    assign bus0.op = op_s;
    assign bus1.op = op_s;
    assign bus2.op = op_s;
    assign bus0.operand1 = a_s;
    assign bus1.operand1 = a_s;
    assign bus2.operand1 = a_s;
    assign bus0.operand2 = b_s;
    assign bus1.operand2 = b_s;
    assign bus2.operand2 = b_s;
    assign busy_w = {bus2.busy, bus1.busy, bus0.busy};
    assign done_w = {bus2.done, bus1.done, bus0.done};
    assign res_w[0] = bus0.result;
    assign res_w[1] = bus1.result;
    assign res_w[2] = bus2.result;

    muldiv_iterative_unit #(.XLEN(32), .MUL_BITS(1), .EARLY_OUT(1)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0));
    muldiv_iterative_unit #(.XLEN(32), .MUL_BITS(4), .EARLY_OUT(1)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1));
    muldiv_iterative_unit #(.XLEN(32), .MUL_BITS(1), .EARLY_OUT(0)) u_dut2 (
        .clk(clk), .rst(rst), .bus(bus2));

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Launch one op, scramble the inputs afterwards, and check latency, result, busy and pulse width.
    task automatic run_op(input int inst, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                          input string tag);
        int   lat;
        logic busy_gap;
        @(negedge clk);
        op_s = op;
        a_s = a;
        b_s = b;
        start_s[inst] = 1'b1;
        @(posedge clk);
        #1;
        start_s[inst] = 1'b0;
        a_s = 32'hDEAD_BEEF;
        b_s = 32'h0000_0000;
        op_s = 3'd5;
        lat = 0;
        busy_gap = 1'b0;
        while (done_w[inst] !== 1'b1 && lat < 100) begin
            if (busy_w[inst] !== 1'b1) busy_gap = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        check_value({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check_value({tag, "_result"}, res_w[inst], exp);
        check_value({tag, "_busy_gap"}, 32'(busy_gap), 32'd0);
        check_value({tag, "_busy_at_done"}, 32'(busy_w[inst]), 32'd0);
        @(posedge clk);
        #1;
        check_value({tag, "_done_pulse"}, 32'(done_w[inst]), 32'd0);
        check_value({tag, "_hold"}, res_w[inst], exp);
    endtask

    task automatic count_done(input int inst, input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (done_w[inst] === 1'b1) n++;
        end
    endtask

    initial begin
        int n;
        #2;
        check_value("rst_busy", 32'(busy_w), 32'd0);
        check_value("rst_done", 32'(done_w), 32'd0);
        check_value("rst_result0", res_w[0], 32'd0);
        check_value("rst_result2", res_w[2], 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        run_op(0, OP_MUL,    32'd7,         32'd6,         32'h0000_002A, 33, "mul_7x6");
        run_op(0, OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulh_min");
        run_op(0, OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu_max");
        run_op(0, OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mulhsu_m1");
        run_op(0, OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, "div_m7_2");
        run_op(0, OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, "rem_m7_2");
        run_op(0, OP_DIVU,   32'd100,       32'd7,         32'd14,        33, "divu_100_7");
        run_op(0, OP_REMU,   32'd100,       32'd7,         32'd2,         33, "remu_100_7");

        // Flush part-way through a multiply: no done, result keeps 2.
        @(negedge clk);
        op_s = OP_MUL;
        a_s = 32'd9;
        b_s = 32'd9;
        start_s[0] = 1'b1;
        @(posedge clk);
        #1;
        start_s[0] = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush_s = 1'b1;
        @(posedge clk);
        #1;
        flush_s = 1'b0;
        check_value("flush_busy", 32'(busy_w[0]), 32'd0);
        check_value("flush_done", 32'(done_w[0]), 32'd0);
        check_value("flush_result", res_w[0], 32'd2);
        run_op(0, OP_MUL, 32'd3, 32'd5, 32'd15, 33, "mul_after_flush");

        // Flush together with start in IDLE drops the start.
        @(negedge clk);
        op_s = OP_MUL;
        a_s = 32'd4;
        b_s = 32'd4;
        start_s[0] = 1'b1;
        flush_s = 1'b1;
        @(posedge clk);
        #1;
        start_s[0] = 1'b0;
        flush_s = 1'b0;
        check_value("idle_flush_busy", 32'(busy_w[0]), 32'd0);
        count_done(0, 40, n);
        check_value("idle_flush_no_done", 32'(n), 32'd0);
        check_value("idle_flush_result", res_w[0], 32'd15);

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        op_s = OP_DIVU;
        a_s = 32'd1000;
        b_s = 32'd3;
        start_s[0] = 1'b1;
        @(posedge clk);
        #1;
        start_s[0] = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_value("arst_busy", 32'(busy_w[0]), 32'd0);
        check_value("arst_done", 32'(done_w[0]), 32'd0);
        check_value("arst_result", res_w[0], 32'd0);
        @(negedge clk);
        rst = 1'b1;
        count_done(0, 40, n);
        check_value("arst_no_done", 32'(n), 32'd0);

        // Start held high through most of the op is only accepted once.
        @(negedge clk);
        op_s = OP_DIVU;
        a_s = 32'd100;
        b_s = 32'd7;
        start_s[0] = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        start_s[0] = 1'b0;
        count_done(0, 40, n);
        check_value("held_start_dones", 32'(n), 32'd1);
        check_value("held_start_result", res_w[0], 32'd14);

        run_op(0, OP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, "eo_divu_by0");
        run_op(0, OP_REM,  32'd5,         32'd0,         32'd5,         1, "eo_rem_by0");
        run_op(0, OP_DIV,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 1, "eo_div_neg_by0");
        run_op(0, OP_REM,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1, "eo_rem_neg_by0");
        run_op(0, OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "eo_div_ovf");
        run_op(0, OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, "eo_rem_ovf");

        run_op(1, OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 9, "r16_mulh");
        run_op(1, OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 9, "r16_mulhu");
        run_op(1, OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 9, "r16_mulhsu");
        run_op(1, OP_MUL,    32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, 9, "r16_mul_neg");

        run_op(2, OP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 33, "it_divu_by0");
        run_op(2, OP_REM,  32'd5,         32'd0,         32'd5,         33, "it_rem_by0");
        run_op(2, OP_DIV,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 33, "it_div_neg_by0");
        run_op(2, OP_REM,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 33, "it_rem_neg_by0");
        run_op(2, OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, "it_div_ovf");
        run_op(2, OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33, "it_rem_ovf");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
